// File: rtl/vedic_mult_pkg.sv
// Shared types and constants for the sequential 64x64 Vedic multiplier.
// Holds the FSM state enum and the per-index partial-product shift helper.
package vedic_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         HALF_W   = 32;
    localparam int         PROD_W   = 128;
    localparam logic [1:0] IDX_LAST = 2'd3;

    // Shift for partial products in the order aL*bL, aL*bH, aH*bL, aH*bH.
    function automatic logic [6:0] pp_shift(input logic [1:0] idx);
        case (idx)
            2'd0:    pp_shift = 7'd0;
            2'd3:    pp_shift = 7'd64;
            default: pp_shift = 7'd32;
        endcase
    endfunction

endpackage

// File: rtl/vedic_mul32.sv
// Combinational 32x32->64 Urdhva-Tiryagbhyam multiplier.
// Four 16-bit vertical-crosswise cells are combined with the same crosswise rule.
module vedic_mul32
    import vedic_mult_pkg::*;
(
    input  logic [HALF_W-1:0]   x_i,
    input  logic [HALF_W-1:0]   y_i,
    output logic [2*HALF_W-1:0] p_o
);

    // Column k collects every bit pair u[i]&v[j] with i+j==k.
    function automatic logic [31:0] vedic16(input logic [15:0] u, input logic [15:0] v);
        logic [31:0] sum;
        logic [4:0]  col;
        sum = '0;
        for (int k = 0; k < 31; k++) begin
            col = '0;
            for (int i = ((k > 15) ? k - 15 : 0); i <= ((k < 15) ? k : 15); i++) begin
                col = col + {4'd0, u[4'(i)] & v[4'(k - i)]};
            end
            sum = sum + ({27'd0, col} << k);
        end
        return sum;
    endfunction

    logic [31:0] cell_p [4];

    // Cell gi multiplies x half (gi>>1) by y half (gi&1).
    for (genvar gi = 0; gi < 4; gi++) begin : g_cell
        assign cell_p[gi] = vedic16(x_i[(gi >> 1) * 16 +: 16], y_i[(gi & 1) * 16 +: 16]);
    end

    assign p_o = {32'd0, cell_p[0]}
               + ({32'd0, cell_p[1]} << 16)
               + ({32'd0, cell_p[2]} << 16)
               + {cell_p[3], 32'd0};

endmodule

// File: rtl/vedic_mult64_seq.sv
// Sequential 64x64 multiplier: one shared 32x32 Vedic core over four cycles.
// Define VEDIC_MULT_ZERO_SKIP_EN to finish zero-operand products one cycle after capture.
module vedic_mult64_seq
    import vedic_mult_pkg::*;
#(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] z
);

    state_t                 state_q;
    logic [1:0]             idx_q;
    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic [PROD_W-1:0]      acc_q;
    logic [PROD_W-1:0]      acc_d;
    logic [PROD_W-1:0]      z_q;
    logic                   out_valid_q;
    logic [HALF_W-1:0]      a_sel;
    logic [HALF_W-1:0]      b_sel;
    logic [2*HALF_W-1:0]    pp;
    logic [PROD_W-1:0]      pp_shifted;
    logic                   zero_op;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign z         = z_q;

    // idx bit 1 picks the a half, bit 0 picks the b half.
    assign a_sel = idx_q[1] ? a_q[W-1:HALF_W] : a_q[HALF_W-1:0];
    assign b_sel = idx_q[0] ? b_q[W-1:HALF_W] : b_q[HALF_W-1:0];

    vedic_mul32 u_core (
        .x_i (a_sel),
        .y_i (b_sel),
        .p_o (pp)
    );

    assign pp_shifted = {{(PROD_W - 2*HALF_W){1'b0}}, pp} << pp_shift(idx_q);
    assign acc_d      = acc_q + pp_shifted;

`ifdef VEDIC_MULT_ZERO_SKIP_EN
    assign zero_op = (a_q == '0) || (b_q == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        idx_q   <= 2'd0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (zero_op) begin
                        z_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        if (idx_q == IDX_LAST) begin
                            z_q         <= acc_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult64_seq.sv
// Self-checking bench for vedic_mult64_seq: vector table, corner sequences, random stream.
// Inputs change 1 time unit after the rising edge; the scoreboard samples on the falling edge.
module tb_vedic_mult64_seq;

`ifdef VEDIC_MULT_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [63:0]  a = '0;
    logic [63:0]  b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] z;

    vedic_mult64_seq #(.W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_out = 0;
    logic [127:0] exp_q [$];
    logic [127:0] sb_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push the reference product on acceptance, pop on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 128'd1, 128'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_z", z, sb_e);
                    $display("txn %0d: z=%h expected=%h", n_out, z, sb_e);
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({64'd0, a} * {64'd0, b});
        end
    end

    typedef struct {
        logic [63:0]  va;
        logic [63:0]  vb;
        logic [127:0] vz;
        int           vlat;
    } vec_t;

    vec_t vecs [8];

    task automatic run_one(input logic [63:0] va, input logic [63:0] vb,
                           input logic [127:0] vz, input int vlat, input string name);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        check({name, "_ready_before"}, {127'd0, in_ready}, 128'd1);
        a = va;
        b = vb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a = '1;
        b = '1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(vlat));
        check({name, "_z"}, z, vz);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_out_valid_after"}, {127'd0, out_valid}, 128'd0);
        check({name, "_in_ready_after"}, {127'd0, in_ready}, 128'd1);
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 9))
            0:       rnd_op = 64'd0;
            1:       rnd_op = '1;
            default: rnd_op = {$urandom, $urandom};
        endcase
    endfunction

    int           cnt;
    int           t;
    int           sent;
    int           base;
    logic [127:0] z_hold;

    initial begin
        vecs[0] = '{64'h0000_0001_0000_0003, 64'h0000_0002_0000_0005,
                    128'h0000_0000_0000_0002_0000_000B_0000_000F, 4};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 4};
        vecs[2] = '{64'd0, 64'h1234, 128'd0, ZLAT};
        vecs[3] = '{64'd3, 64'd4, 128'd12, 4};
        vecs[4] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000,
                    128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000, 4};
        vecs[5] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
                    128'h0000_0000_0000_0001_0000_0000_0000_0000, 4};
        vecs[6] = '{64'h0000_0002_0000_0000, 64'd7,
                    128'h0000_0000_0000_0000_0000_000E_0000_0000, 4};
        vecs[7] = '{64'hDEAD, 64'd0, 128'd0, ZLAT};

        // Reset state and first cycle out of reset.
        step();
        step();
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_z", z, 128'd0);
        rst = 1'b0;
        #1;
        check("first_cycle_in_ready", {127'd0, in_ready}, 128'd1);

        for (int i = 0; i < 8; i++)
            run_one(vecs[i].va, vecs[i].vb, vecs[i].vz, vecs[i].vlat, $sformatf("vec%0d", i));

        // Reset landing on E2 discards the in-flight product.
        a = 64'd5;
        b = 64'd7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_z", z, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        run_one(64'd3, 64'd4, 128'd12, 4, "after_rst");

        // Backpressure: DONE holds, in_valid pulse ignored, single handshake on release.
        a = 64'h0000_0123_4567_89AB;
        b = 64'h0000_0000_0000_1000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            step();
            t++;
        end
        z_hold = z;
        check("bp_z_value", z_hold, 128'h0000_0000_0000_0000_0012_3456_789A_B000);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                a = 64'd99;
                b = 64'd99;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            check("bp_z_stable", z, z_hold);
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_out_valid", {127'd0, out_valid}, 128'd0);
        check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid)
                cnt++;
        end
        check("bp_pulse_not_queued", 128'(cnt), 128'd0);
        check("bp_scoreboard_empty", 128'(exp_q.size()), 128'd0);

        // Peak throughput: one product every 6 cycles.
        a = 64'h1111_2222_3333_4444;
        b = 64'h5555_6666_7777_8888;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (out_valid)
                cnt++;
        end
        check("throughput_done_cycles", 128'(cnt), 128'd10);
        in_valid = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 50) begin
            step();
            t++;
        end
        check("throughput_drained", 128'(exp_q.size()), 128'd0);

        // Random stream with stalls on both sides.
        sent = 0;
        base = n_out;
        t = 0;
        while ((sent < 1000 || exp_q.size() != 0 || out_valid) && t < 40000) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                a = rnd_op();
                b = rnd_op();
                in_valid = 1'b1;
                if (in_ready)
                    sent++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_outputs", 128'(n_out - base), 128'd1000);
        check("stream_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
